// File: rtl/irq_trap_arbiter.sv
// Machine-level interrupt arbiter: registers CLINT/platform sources into a mip view,
// picks MEI > MSI > MTI, and runs a request/handler handshake with the core.
module irq_trap_arbiter #(
  parameter bit          EXT_EDGE       = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_irq_i,
  input  logic        software_irq_i,
  input  logic        ext_irq_i,
  input  logic        mstatus_mie_i,
  input  logic [31:0] mie_i,
  input  logic        trap_ack_i,
  input  logic        mret_i,
  output logic        trap_req_o,
  output logic [31:0] trap_cause_o,
  output logic [31:0] mip_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_MEI = 4'd11;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_e;

  state_e     state_q, state_d;
  logic [3:0] code_q, code_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
  logic       mti_q, msi_q, mei_q, mei_d;
  logic       ack_mei;
  logic       pend_mei, pend_msi, pend_mti, pend_lat;
  logic       unused_mie;

  assign unused_mie = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

  assign pend_mei = mei_q & mie_i[11] & mstatus_mie_i;
  assign pend_msi = msi_q & mie_i[3]  & mstatus_mie_i;
  assign pend_mti = mti_q & mie_i[7]  & mstatus_mie_i;

  always_comb begin
    pend_lat = 1'b0;
    case (code_q)
      CODE_MEI: pend_lat = pend_mei;
      CODE_MSI: pend_lat = pend_msi;
      CODE_MTI: pend_lat = pend_mti;
      default:  pend_lat = 1'b0;
    endcase
  end

  // Sticky MEI in edge mode: a new rising edge beats a concurrent acknowledge.
  generate
    if (EXT_EDGE) begin : g_ext_edge
      logic ext_prev_q;
      always_ff @(posedge clk) begin
        if (rst) ext_prev_q <= 1'b0;
        else     ext_prev_q <= ext_irq_i;
      end
      always_comb begin
        mei_d = mei_q;
        if (ext_irq_i && !ext_prev_q) mei_d = 1'b1;
        else if (ack_mei)             mei_d = 1'b0;
      end
    end else begin : g_ext_level
      always_comb mei_d = ext_irq_i;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    cnt_d     = '0;
    timeout_d = 1'b0;
    ack_mei   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_mei || pend_msi || pend_mti) begin
          state_d = REQ;
          code_d  = pend_mei ? CODE_MEI : (pend_msi ? CODE_MSI : CODE_MTI);
        end
      end
      REQ: begin
        if (trap_ack_i) begin
          state_d = HANDLER;
          ack_mei = (code_q == CODE_MEI);
        end else if (!pend_lat) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HANDLER: begin
        if (mret_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      code_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      mti_q     <= 1'b0;
      msi_q     <= 1'b0;
      mei_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      mti_q     <= timer_irq_i;
      msi_q     <= software_irq_i;
      mei_q     <= mei_d;
    end
  end

  assign trap_req_o   = (state_q == REQ);
  assign trap_cause_o = (state_q == REQ) ? {1'b1, 27'b0, code_q} : 32'h0;
  assign mip_o        = {20'b0, mei_q, 3'b0, mti_q, 3'b0, msi_q, 3'b0};
  assign busy_o       = (state_q == HANDLER);
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_irq_trap_arbiter.sv
// Directed, table-driven bench for irq_trap_arbiter: level-mode instance for the main
// table, edge-mode instance for the sticky MEI sequence.
module tb_irq_trap_arbiter;

  localparam logic [31:0] C0 = 32'h0;
  localparam logic [31:0] C3 = 32'h8000_0003;
  localparam logic [31:0] C7 = 32'h8000_0007;
  localparam logic [31:0] CB = 32'h8000_000B;

  typedef struct {
    logic        rst, tim, sw, ext, mst;
    logic [31:0] mie;
    logic        ack, mret;
    logic        req;
    logic [31:0] cause;
    logic [31:0] mip;
    logic        busy, to;
  } vec_t;

  logic clk = 1'b0;
  logic rst, timer_irq, software_irq, ext_irq, mstatus_mie, trap_ack, mret;
  logic [31:0] mie;
  logic l_req, l_busy, l_to, e_req, e_busy, e_to;
  logic [31:0] l_cause, l_mip, e_cause, e_mip;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  irq_trap_arbiter #(.EXT_EDGE(1'b0), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .timer_irq_i(timer_irq), .software_irq_i(software_irq),
    .ext_irq_i(ext_irq), .mstatus_mie_i(mstatus_mie), .mie_i(mie),
    .trap_ack_i(trap_ack), .mret_i(mret), .trap_req_o(l_req), .trap_cause_o(l_cause),
    .mip_o(l_mip), .busy_o(l_busy), .timeout_o(l_to)
  );

  irq_trap_arbiter #(.EXT_EDGE(1'b1), .TIMEOUT_CYCLES(8)) dut_e (
    .clk(clk), .rst(rst), .timer_irq_i(timer_irq), .software_irq_i(software_irq),
    .ext_irq_i(ext_irq), .mstatus_mie_i(mstatus_mie), .mie_i(mie),
    .trap_ack_i(trap_ack), .mret_i(mret), .trap_req_o(e_req), .trap_cause_o(e_cause),
    .mip_o(e_mip), .busy_o(e_busy), .timeout_o(e_to)
  );

  function automatic vec_t mk(input logic r, t, s, e, m, input logic [31:0] ie,
                              input logic a, mr, q, input logic [31:0] c,
                              input logic [31:0] p, input logic b, o);
    vec_t v;
    v.rst = r; v.tim = t; v.sw = s; v.ext = e; v.mst = m; v.mie = ie;
    v.ack = a; v.mret = mr; v.req = q; v.cause = c; v.mip = p; v.busy = b; v.to = o;
    return v;
  endfunction

  task automatic cmp(input string tag, input int idx, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s[%0d] %s: got %h expected %h", tag, idx, name, act, exp);
    end
  endtask

  task automatic step(input string tag, input int idx, input vec_t v, input bit use_e);
    logic        q, b, o;
    logic [31:0] c, p;
    rst = v.rst; timer_irq = v.tim; software_irq = v.sw; ext_irq = v.ext;
    mstatus_mie = v.mst; mie = v.mie; trap_ack = v.ack; mret = v.mret;
    @(posedge clk);
    #1;
    q = use_e ? e_req   : l_req;
    c = use_e ? e_cause : l_cause;
    p = use_e ? e_mip   : l_mip;
    b = use_e ? e_busy  : l_busy;
    o = use_e ? e_to    : l_to;
    $display("[TB] %s[%0d] req=%0b cause=%h mip=%h busy=%0b to=%0b", tag, idx, q, c, p, b, o);
    cmp(tag, idx, "trap_req", {31'b0, q}, {31'b0, v.req});
    cmp(tag, idx, "trap_cause", c, v.cause);
    cmp(tag, idx, "mip", p, v.mip);
    cmp(tag, idx, "busy", {31'b0, b}, {31'b0, v.busy});
    cmp(tag, idx, "timeout", {31'b0, o}, {31'b0, v.to});
  endtask

  vec_t tbl[$];
  vec_t edg[$];

  initial begin
    rst = 1'b1; timer_irq = 1'b0; software_irq = 1'b0; ext_irq = 1'b0;
    mstatus_mie = 1'b0; mie = '0; trap_ack = 1'b0; mret = 1'b0;

    // reset with every source active, then first request two edges after release
    repeat (3) tbl.push_back(mk(1,1,1,1,1,32'h888,0,0, 0,C0,32'h000,0,0));
    tbl.push_back(mk(0,1,0,0,1,32'h080,0,0, 0,C0,32'h080,0,0));
    tbl.push_back(mk(0,1,0,0,1,32'h080,0,0, 1,C7,32'h080,0,0));
    // single timer: ack, handler, mret with timer still high
    tbl.push_back(mk(0,1,0,0,1,32'h880,1,0, 0,C0,32'h080,1,0));
    tbl.push_back(mk(0,1,0,0,1,32'h880,0,0, 0,C0,32'h080,1,0));
    tbl.push_back(mk(0,1,0,0,1,32'h880,0,1, 0,C0,32'h080,0,0));
    tbl.push_back(mk(0,1,0,0,1,32'h880,0,0, 1,C7,32'h080,0,0));
    tbl.push_back(mk(0,1,0,0,1,32'h880,1,0, 0,C0,32'h080,1,0));
    tbl.push_back(mk(0,0,0,0,1,32'h880,0,1, 0,C0,32'h000,0,0));
    tbl.push_back(mk(0,0,0,0,1,32'h880,0,0, 0,C0,32'h000,0,0));
    // simultaneous sources: MEI, then MSI, then MTI
    tbl.push_back(mk(0,1,1,1,1,32'h888,0,0, 0,C0,32'h888,0,0));
    tbl.push_back(mk(0,1,1,1,1,32'h888,0,0, 1,CB,32'h888,0,0));
    tbl.push_back(mk(0,1,1,0,1,32'h888,1,0, 0,C0,32'h088,1,0));
    tbl.push_back(mk(0,1,1,0,1,32'h888,0,1, 0,C0,32'h088,0,0));
    tbl.push_back(mk(0,1,1,0,1,32'h888,0,0, 1,C3,32'h088,0,0));
    tbl.push_back(mk(0,1,0,0,1,32'h888,1,0, 0,C0,32'h080,1,0));
    tbl.push_back(mk(0,1,0,0,1,32'h888,0,1, 0,C0,32'h080,0,0));
    // withdraw after 5 request cycles when the timer drops
    repeat (4) tbl.push_back(mk(0,1,0,0,1,32'h888,0,0, 1,C7,32'h080,0,0));
    tbl.push_back(mk(0,0,0,0,1,32'h888,0,0, 1,C7,32'h000,0,0));
    repeat (2) tbl.push_back(mk(0,0,0,0,1,32'h888,0,0, 0,C0,32'h000,0,0));
    // withdraw when mstatus.MIE clears
    tbl.push_back(mk(0,1,0,0,1,32'h888,0,0, 0,C0,32'h080,0,0));
    repeat (2) tbl.push_back(mk(0,1,0,0,1,32'h888,0,0, 1,C7,32'h080,0,0));
    tbl.push_back(mk(0,1,0,0,0,32'h888,0,0, 0,C0,32'h080,0,0));
    tbl.push_back(mk(0,0,0,0,0,32'h888,0,0, 0,C0,32'h000,0,0));
    // timeout after 8 request cycles, one-cycle gap, then re-request
    tbl.push_back(mk(0,0,1,0,1,32'h888,0,0, 0,C0,32'h008,0,0));
    repeat (8) tbl.push_back(mk(0,0,1,0,1,32'h888,0,0, 1,C3,32'h008,0,0));
    tbl.push_back(mk(0,0,1,0,1,32'h888,0,0, 0,C0,32'h008,0,1));
    tbl.push_back(mk(0,0,1,0,1,32'h888,0,0, 1,C3,32'h008,0,0));
    tbl.push_back(mk(0,0,1,0,1,32'h888,1,0, 0,C0,32'h008,1,0));
    tbl.push_back(mk(0,0,0,0,1,32'h888,0,1, 0,C0,32'h000,0,0));
    // stray ack/mret in IDLE are ignored
    tbl.push_back(mk(0,0,0,0,1,32'h888,1,1, 0,C0,32'h000,0,0));
    // ack beats withdraw; pending ignored in handler; reset aborts REQ and HANDLER
    tbl.push_back(mk(0,1,0,0,1,32'h888,0,0, 0,C0,32'h080,0,0));
    tbl.push_back(mk(0,1,0,0,1,32'h888,0,0, 1,C7,32'h080,0,0));
    tbl.push_back(mk(0,1,0,0,0,32'h888,1,0, 0,C0,32'h080,1,0));
    tbl.push_back(mk(0,1,0,0,1,32'h888,0,0, 0,C0,32'h080,1,0));
    tbl.push_back(mk(1,1,0,0,1,32'h888,0,0, 0,C0,32'h000,0,0));
    tbl.push_back(mk(0,1,0,0,1,32'h888,0,0, 0,C0,32'h080,0,0));
    tbl.push_back(mk(0,1,0,0,1,32'h888,0,0, 1,C7,32'h080,0,0));
    tbl.push_back(mk(1,1,0,0,1,32'h888,0,0, 0,C0,32'h000,0,0));
    tbl.push_back(mk(0,0,0,0,1,32'h888,0,0, 0,C0,32'h000,0,0));

    foreach (tbl[i]) step("main", i, tbl[i], 1'b0);

    // edge-mode MEI: one-cycle pulse sticks; a pulse coincident with ack keeps it set
    edg.push_back(mk(1,0,0,0,1,32'h800,0,0, 0,C0,32'h000,0,0));
    edg.push_back(mk(0,0,0,1,1,32'h800,0,0, 0,C0,32'h800,0,0));
    edg.push_back(mk(0,0,0,0,1,32'h800,0,0, 1,CB,32'h800,0,0));
    repeat (2) edg.push_back(mk(0,0,0,0,1,32'h800,0,0, 1,CB,32'h800,0,0));
    edg.push_back(mk(0,0,0,1,1,32'h800,1,0, 0,C0,32'h800,1,0));
    edg.push_back(mk(0,0,0,0,1,32'h800,0,0, 0,C0,32'h800,1,0));
    edg.push_back(mk(0,0,0,0,1,32'h800,0,1, 0,C0,32'h800,0,0));
    edg.push_back(mk(0,0,0,0,1,32'h800,0,0, 1,CB,32'h800,0,0));
    edg.push_back(mk(0,0,0,0,1,32'h800,1,0, 0,C0,32'h000,1,0));
    edg.push_back(mk(0,0,0,0,1,32'h800,0,1, 0,C0,32'h000,0,0));
    edg.push_back(mk(0,0,0,0,1,32'h800,0,0, 0,C0,32'h000,0,0));

    foreach (edg[i]) begin
      step("edge", i, edg[i], 1'b1);
      // the level-mode instance sees the same pulse but must drop MEI right after it
      if (i == 2) cmp("edge", i, "level_mip", l_mip, 32'h000);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/irq_trap_arbiter.md
Name: irq_trap_arbiter

Overview:
- Sits directly downstream of the CLINT and consumes its timer_irq_o and software_irq_o outputs, together with the platform external interrupt line.
- Registers the sources into a machine-interrupt-pending (mip) view and applies the mie and mstatus.MIE enables.
- Selects one pending interrupt by RISC-V priority and presents a single trap request, with its cause, to the core pipeline.
- Holds off further requests until the core handshakes the trap and later retires mret.

Parameters:
- EXT_EDGE, 0, 0: external interrupt is level-sensitive; 1: rising edge sets a sticky pending bit.
- TIMEOUT_CYCLES, 64, REQ cycles without trap_ack_i before the request is withdrawn; legal range 2..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- timer_irq_i  in  1  level, from CLINT timer_irq_o.
- software_irq_i  in  1  level, from CLINT software_irq_o.
- ext_irq_i  in  1  platform external interrupt.
- mstatus_mie_i  in  1  global machine interrupt enable.
- mie_i  in  32  machine interrupt enable CSR; only bits 3, 7 and 11 are used.
- trap_ack_i  in  1  core accepts the presented trap this cycle.
- mret_i  in  1  single-cycle pulse when the core retires mret.
- trap_req_o  out  1  trap request to the core.
- trap_cause_o  out  32  mcause value for the request.
- mip_o  out  32  registered pending bits 3, 7 and 11; all other bits 0.
- busy_o  out  1  a trap has been acknowledged and the handler is running.
- timeout_o  out  1  one-cycle pulse when a request is withdrawn on timeout.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: trap_req_o=0, trap_cause_o=0, mip_o=0, busy_o=0, timeout_o=0; FSM in IDLE; timeout counter=0; sticky external bit=0. Reset asserted mid-operation aborts any state within one cycle.
- mip update: mip_o[7] and mip_o[3] are registered copies of timer_irq_i and software_irq_i.
- mip_o[11]: registered copy of ext_irq_i when EXT_EDGE=0. When EXT_EDGE=1 it is sticky: set on a 0→1 edge of ext_irq_i and cleared on a trap_ack_i whose latched code is 11. Set wins over clear in the same cycle.
- Pending: pend = mip_o & mie_i & {32{mstatus_mie_i}}.
- Priority: code 11 (MEI) > code 3 (MSI) > code 7 (MTI).
- Cause encoding: trap_cause_o = 32'h8000_0000 | code.
- Latency: a source asserted before edge N appears in mip_o after edge N. trap_req_o rises after edge N+1, so the minimum latency is 2 cycles.
- FSM IDLE: if any pend bit is set, latch the highest-priority code and go to REQ with trap_req_o=1. Otherwise trap_req_o=0. mret_i is ignored in IDLE.
- FSM REQ:
  - trap_cause_o holds the latched code; it is not re-arbitrated even if a higher-priority source arrives.
  - Counter increments every cycle in REQ.
  - trap_ack_i=1: go to HANDLER, trap_req_o=0, busy_o=1, counter cleared.
  - Else if pend[latched code]=0 (source dropped or disabled): withdraw; go to IDLE, trap_req_o=0, no timeout pulse.
  - Else if counter==TIMEOUT_CYCLES-1: go to IDLE, trap_req_o=0, timeout_o=1 for one cycle.
  - Precedence: ack > withdraw > timeout.
  - mret_i is ignored in REQ.
- FSM HANDLER:
  - busy_o=1 and trap_req_o=0; no nesting, so pending changes are ignored.
  - On mret_i go to IDLE with busy_o=0. If pend is still nonzero, the next request rises one cycle later, re-arbitrated afresh.
- trap_ack_i while not in REQ is ignored.
- timeout_o is a registered pulse, asserted only in the cycle after the timeout transition.

Test Plan:
- Reset sequence: assert rst 3 cycles with all sources high → every output 0 throughout. After release, mstatus_mie_i=1 and mie_i=0x80 give trap_req_o=1 exactly 2 cycles after the first sampled edge.
- Single timer interrupt: timer_irq_i=1, mie_i=0x880, mstatus_mie_i=1 → trap_req_o=1 with trap_cause_o=0x8000_0007. Ack → busy_o=1. mret_i while the timer is still high → new request 1 cycle after IDLE.
- Simultaneous sources: all three high, mie_i=0x888 → cause 0x8000_000B. After ack and mret with ext low → cause 0x8000_0003; then after that ack and mret → 0x8000_0007.
- Withdraw: timer request pending, no ack, timer_irq_i drops after 5 cycles → trap_req_o=0 and timeout_o stays 0. Repeat with mstatus_mie_i cleared instead → same result.
- Timeout: TIMEOUT_CYCLES=8, software_irq_i held high, no ack → trap_req_o high 8 cycles, then low, timeout_o pulses once. A re-request follows 1 cycle later.
- Edge mode: EXT_EDGE=1, ext_irq_i pulsed 1 cycle → mip_o[11] stays 1 until ack, cause 0x8000_000B. A second pulse coincident with the ack cycle → mip_o[11] remains 1.
